// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
// Optional decode bypass of the pending write is enabled with macro WB_FWD_EN.
module reg_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [ADDR_WIDTH-1:0] req_addr2,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  input  logic [DATA_WIDTH-1:0] req_data2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [CNT_WIDTH-1:0]  conflict_cnt,
  input  logic                  cnt_clr
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr1,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2
`endif
);

  logic [1:0]            rr_ptr;
  logic [1:0]            rr_ptr_nxt;
  logic [2:0]            grant;
  logic                  xfer;
  logic                  conflict;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // First valid requester starting from rr_ptr, wrapping mod 3.
  always_comb begin
    grant = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (req_valid[1])      grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if (req_valid[2])      grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
      end
      default: begin
        if (req_valid[0])      grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
      end
    endcase
  end

  assign req_ready = grant & {3{resetn}};
  assign xfer      = |grant;
  assign conflict  = (req_valid[0] & req_valid[1]) |
                     (req_valid[0] & req_valid[2]) |
                     (req_valid[1] & req_valid[2]);

  always_comb begin
    sel_addr   = req_addr0;
    sel_data   = req_data0;
    rr_ptr_nxt = rr_ptr;
    if (grant[0]) begin
      rr_ptr_nxt = 2'd1;
    end else if (grant[1]) begin
      sel_addr   = req_addr1;
      sel_data   = req_data1;
      rr_ptr_nxt = 2'd2;
    end else if (grant[2]) begin
      sel_addr   = req_addr2;
      sel_data   = req_data2;
      rr_ptr_nxt = 2'd0;
    end
  end

  // Writes to r0 are consumed but never enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr   <= 2'd0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      rf_wen <= xfer && (sel_addr != '0);
      if (xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt <= '0;
    end else if (cnt_clr) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef WB_FWD_EN
  assign fwd_hit1  = rf_wen && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != '0);
  assign fwd_hit2  = rf_wen && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != '0);
  assign fwd_data1 = rf_wdata;
  assign fwd_data2 = rf_wdata;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed vector bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [4:0]  req_addr0 = '0, req_addr1 = '0, req_addr2 = '0;
  logic [31:0] req_data0 = '0, req_data1 = '0, req_data2 = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] conflict_cnt;
  logic        cnt_clr = 1'b0;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_raddr1 = '0, fwd_raddr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int napplied = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr)
`ifdef WB_FWD_EN
    , .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        clr;
    logic [2:0]  exp_ready;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    napplied++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn    = 1'b0;
    req_valid = 3'b000;
    cnt_clr   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic setv(input vec_t v);
    req_valid = v.valid;
    req_addr0 = v.a0; req_addr1 = v.a1; req_addr2 = v.a2;
    req_data0 = v.d0; req_data1 = v.d1; req_data2 = v.d2;
    cnt_clr   = v.clr;
  endtask

  function automatic vec_t mk(input logic [2:0] valid,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic clr, input logic [2:0] rdy,
                              input logic wen, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [15:0] cnt);
    vec_t v;
    v.valid = valid; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.a2 = a2; v.d2 = d2; v.clr = clr; v.exp_ready = rdy;
    v.exp_wen = wen; v.exp_waddr = wa; v.exp_wdata = wd; v.exp_cnt = cnt;
    return v;
  endfunction

  initial begin
    // valid, a0,d0, a1,d1, a2,d2, clr | ready, wen, waddr, wdata, cnt
    vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,  3'b000, 0, 0, 32'h0, 0);
    vecs[1]  = mk(3'b111, 1, 32'h1111_0001, 2, 32'h2222_0002, 4, 32'h4444_0004, 0,
                  3'b001, 1, 1, 32'h1111_0001, 1);
    vecs[2]  = mk(3'b110, 0, 0, 2, 32'h2222_0002, 4, 32'h4444_0004, 0,
                  3'b010, 1, 2, 32'h2222_0002, 2);
    vecs[3]  = mk(3'b100, 0, 0, 0, 0, 4, 32'h4444_0004, 0,
                  3'b100, 1, 4, 32'h4444_0004, 2);
    vecs[4]  = mk(3'b010, 0, 0, 0, 32'h1234, 0, 0, 0,  3'b010, 0, 0, 32'h1234, 2);
    vecs[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,  3'b000, 0, 0, 32'h1234, 2);
    vecs[6]  = mk(3'b001, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,  3'b001, 1, 3, 32'hDEAD_BEEF, 2);
    vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,  3'b000, 0, 3, 32'hDEAD_BEEF, 2);
    vecs[8]  = mk(3'b101, 5, 32'hA, 0, 0, 6, 32'hB, 0,  3'b100, 1, 6, 32'hB, 3);
    vecs[9]  = mk(3'b001, 5, 32'hA, 0, 0, 0, 0, 0,  3'b001, 1, 5, 32'hA, 3);
    vecs[10] = mk(3'b011, 8, 32'hC, 9, 32'hD, 0, 0, 1,  3'b010, 1, 9, 32'hD, 0);
    vecs[11] = mk(3'b001, 8, 32'hC, 0, 0, 0, 0, 0,  3'b001, 1, 8, 32'hC, 0);
    vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0,  3'b000, 0, 8, 32'hC, 0);

    // Asynchronous reset while a write sits in the output stage.
    do_reset();
    check("reset_wen", {31'b0, rf_wen}, 32'h0);
    check("reset_cnt", {16'b0, conflict_cnt}, 32'h0);
    @(negedge clk);
    req_valid = 3'b001; req_addr0 = 5; req_data0 = 32'h5555_AAAA;
    @(posedge clk); #1;
    check("pre_reset_wen", {31'b0, rf_wen}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("async_wen", {31'b0, rf_wen}, 32'h0);
    check("async_waddr", {27'b0, rf_waddr}, 32'h0);
    check("async_ready", {29'b0, req_ready}, 32'h0);
    @(negedge clk);
    req_valid = 3'b000;
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_reset_wen", {31'b0, rf_wen}, 32'h0);
    end

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      setv(vecs[i]);
      #1;
      check($sformatf("v%0d_ready", i), {29'b0, req_ready}, {29'b0, vecs[i].exp_ready});
      @(posedge clk); #1;
      check($sformatf("v%0d_wen", i), {31'b0, rf_wen}, {31'b0, vecs[i].exp_wen});
      check($sformatf("v%0d_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].exp_waddr});
      check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_cnt", i), {16'b0, conflict_cnt}, {16'b0, vecs[i].exp_cnt});
    end

    // Counter saturation under continuous two-way contention, then clear.
    do_reset();
    @(negedge clk);
    req_valid = 3'b011; req_addr0 = 1; req_addr1 = 2; cnt_clr = 1'b0;
    repeat (65534) @(posedge clk);
    #1 check("cnt_fffe", {16'b0, conflict_cnt}, 32'hFFFE);
    @(posedge clk); #1;
    check("cnt_ffff", {16'b0, conflict_cnt}, 32'hFFFF);
    @(posedge clk); #1;
    check("cnt_sat_hold", {16'b0, conflict_cnt}, 32'hFFFF);
    @(negedge clk) cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("cnt_clr", {16'b0, conflict_cnt}, 32'h0);
    @(negedge clk) cnt_clr = 1'b0;
    @(posedge clk); #1;
    check("cnt_after_clr", {16'b0, conflict_cnt}, 32'h1);

`ifdef WB_FWD_EN
    do_reset();
    @(negedge clk);
    req_valid = 3'b001; req_addr0 = 7; req_data0 = 32'h55;
    @(negedge clk);
    req_valid = 3'b000; fwd_raddr1 = 7; fwd_raddr2 = 0;
    #1;
    check("fwd_hit1", {31'b0, fwd_hit1}, 32'h1);
    check("fwd_data1", fwd_data1, 32'h55);
    check("fwd_hit2_r0", {31'b0, fwd_hit2}, 32'h0);
    fwd_raddr1 = 8;
    #1 check("fwd_hit1_miss", {31'b0, fwd_hit1}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Write-back arbiter for the 32x32 register file's single write port. Three producers (ALU, load unit, mul/div) present write requests over valid/ready handshakes. A round-robin grant picks one per cycle and registers it into a one-deep output stage that drives the register file's wen/waddr/wdata directly. Sits between the execute/memory units and reg_file; also provides a saturating contention counter for performance debug.

Parameters:
DATA_WIDTH, 32, write-data width
ADDR_WIDTH, 5, register address width
CNT_WIDTH, 16, contention counter width

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
req_valid  in  3  per-requester write request; bit0 ALU, bit1 load, bit2 mul/div
req_ready  out  3  per-requester grant/accept, combinational, at most one bit high
req_addr0 / req_addr1 / req_addr2  in  ADDR_WIDTH each  destination register per requester
req_data0 / req_data1 / req_data2  in  DATA_WIDTH each  write data per requester
rf_wen  out  1  register-file write enable, registered
rf_waddr  out  ADDR_WIDTH  register-file write address, registered
rf_wdata  out  DATA_WIDTH  register-file write data, registered
conflict_cnt  out  CNT_WIDTH  cycles with two or more req_valid bits high, saturating
cnt_clr  in  1  synchronous clear of conflict_cnt

Behaviour:
- Reset (async, resetn low): rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, conflict_cnt=0. req_ready is 0 while resetn is low. Reset mid-request drops the in-flight output stage; no write is issued.
- rr_ptr (values 0..2) holds the highest-priority requester. Search order: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
- Grant is combinational. req_ready[i]=1 only for the first valid requester in search order. If no request is valid, req_ready=0.
- Transfer on requester i means req_valid[i] and req_ready[i] are both high at the rising edge.
- Pointer update: after a transfer on i, rr_ptr becomes (i+1) mod 3. With no transfer, rr_ptr holds.
- Requester rule: once req_valid is asserted, addr, data and valid stay stable until the transfer. The arbiter does not check this.
- Output stage, the cycle after a transfer:
  - rf_waddr and rf_wdata take the granted addr/data.
  - rf_wen=1 if the addr is non-zero. rf_wen=0 for addr 0: the request is still consumed (ready given) but the write is suppressed.
  - With no transfer, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
- Latency: a request granted in cycle N appears on rf_* in cycle N+1. The register file commits it at the edge ending N+1. Throughput is one write per cycle; no backpressure from the register file.
- Same destination from two requesters in one cycle: the grant order decides. The loser writes one cycle later, so its value is the final one. Producers needing program-order WAW must not present conflicting writes together.
- conflict_cnt:
  - Increments by 1 in each cycle where popcount(req_valid) >= 2, and saturates at all-ones.
  - cnt_clr has priority over increment and sets the counter to 0 at the edge.
  - Not affected by grants.
- Not stateful beyond rr_ptr, the output stage and the counter. There is no FSM idle/busy state: every cycle is an arbitration cycle.

Optional Feature:
Macro WB_FWD_EN.
- When defined, add ports:
  - fwd_raddr1, fwd_raddr2: in, ADDR_WIDTH.
  - fwd_hit1, fwd_hit2: out, 1.
  - fwd_data1, fwd_data2: out, DATA_WIDTH.
- Behaviour with the macro: fwd_hitK = rf_wen && (rf_waddr == fwd_raddrK) && (fwd_raddrK != 0), and fwd_dataK = rf_wdata, both combinational. This lets decode bypass the write pending in the output stage before the register file commits it.
- Without the macro: the ports do not exist and there is no compare logic.

Test Plan:
1. Reset asserted asynchronously mid-cycle while req_valid=3'b001 and addr=5 -> rf_wen drops to 0 immediately, rr_ptr=0, and no write to r5 after reset release until a new transfer.
2. ALU-only request addr=3, data=0xDEADBEEF -> req_ready=3'b001 the same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF; the cycle after, rf_wen=0.
3. All three valid and held for 3 cycles from reset -> grants in order 001, 010, 100; rf_waddr follows each addr one cycle later; conflict_cnt=2 (cycles with ≥2 valids); rr_ptr returns to 0.
4. Load request to addr=0, data=0x1234 -> req_ready[1]=1, next cycle rf_wen=0, and r0 still reads 0.
5. Force conflict_cnt to 0xFFFE with continuous 2-way contention -> it reaches 0xFFFF and holds; cnt_clr pulse -> 0 the next cycle even though contention continues.
6. WB_FWD_EN defined: ALU writes addr=7, data=0x55 and fwd_raddr1=7 in the output cycle -> fwd_hit1=1, fwd_data1=0x55; with fwd_raddr2=0 -> fwd_hit2=0.
